// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: coin/keypad inputs and dispense/hopper handshakes of the vending controller
interface vend_ctrl_if #(
  parameter int CW = 6
);
  logic          coin5;
  logic          coin10;
  logic          sel_valid;
  logic [1:0]    sel;
  logic          cancel;
  logic          disp_ack;
  logic          chg_ack;
  logic          disp_req;
  logic [1:0]    disp_item;
  logic          chg_req;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          sel_err;
  logic          busy;
  modport master (
    input  coin5, coin10, sel_valid, sel, cancel, disp_ack, chg_ack,
    output disp_req, disp_item, chg_req, credit, coin_reject, sel_err, busy
  );
  modport slave (
    output coin5, coin10, sel_valid, sel, cancel, disp_ack, chg_ack,
    input  disp_req, disp_item, chg_req, credit, coin_reject, sel_err, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction controller (credit, selection, dispense and change handshakes); VEND_TIMEOUT_EN adds an inactivity refund timeout
module vend_ctrl #(
  parameter int CW         = 6,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 6,
  parameter int TO_CYC     = 255
) (
  input logic         clk,
  input logic         rst,
  vend_ctrl_if.master v
);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  localparam logic [CW:0] MAXC = (CW+1)'(MAX_CREDIT);
  state_t        state;
  logic [CW-1:0] credit;
  logic [1:0]    item;
  logic          disp_req;
  logic          chg_req;
  logic          busy;
  logic          coin_reject;
  logic          sel_err;
  logic [CW:0]   sum;
  logic [CW-1:0] sel_price;
  logic [CW-1:0] rem;
  logic          coin_any;
  logic          tmo;
  function automatic logic [CW-1:0] price(input logic [1:0] i);
    return i == 2'd0 ? CW'(PRICE0) : i == 2'd1 ? CW'(PRICE1) : i == 2'd2 ? CW'(PRICE2) : CW'(PRICE3);
  endfunction
  // sum is one bit wider than credit so an over-limit add is detected rather than wrapped
  always_comb begin
    coin_any  = v.coin5 | v.coin10;
    sum       = {1'b0, credit} + {{CW{1'b0}}, v.coin5} + {{(CW-1){1'b0}}, v.coin10, 1'b0};
    sel_price = price(v.sel);
    rem       = credit - price(item);
  end
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] cnt;
  // inactivity counter: runs only in CREDIT and restarts on any coin or selection, accepted or not
  always_ff @(posedge clk)
    cnt <= (rst || state != CREDIT || coin_any || v.sel_valid) ? '0 : cnt + 1'b1;
  assign tmo = state == CREDIT && cnt == TW'(TO_CYC);
`else
  assign tmo = 1'b0 & (TO_CYC != 0);
`endif
  // transaction FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      item        <= '0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      coin_reject <= coin_any;
      sel_err     <= 1'b0;
      case (state)
        IDLE, CREDIT: begin
          if (v.cancel) begin
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
              busy    <= 1'b1;
            end
          end else if (v.sel_valid) begin
            if (credit >= sel_price) begin
              item     <= v.sel;
              state    <= DISPENSE;
              disp_req <= 1'b1;
              busy     <= 1'b1;
            end else
              sel_err <= 1'b1;
          end else if (coin_any) begin
            if (sum <= MAXC) begin
              credit      <= sum[CW-1:0];
              state       <= CREDIT;
              coin_reject <= 1'b0;
            end
          end else if (tmo) begin
            state   <= CHANGE;
            chg_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DISPENSE: begin
          if (v.disp_ack) begin
            credit   <= rem;
            disp_req <= 1'b0;
            state    <= rem != '0 ? CHANGE : IDLE;
            chg_req  <= rem != '0;
            busy     <= rem != '0;
          end
        end
        default: begin
          if (v.chg_ack && credit != '0) begin
            credit  <= credit - 1'b1;
            state   <= credit == CW'(1) ? IDLE : CHANGE;
            chg_req <= credit != CW'(1);
            busy    <= credit != CW'(1);
          end
        end
      endcase
    end
  end
  assign v.credit      = credit;
  assign v.disp_item   = item;
  assign v.disp_req    = disp_req;
  assign v.chg_req     = chg_req;
  assign v.busy        = busy;
  assign v.coin_reject = coin_reject;
  assign v.sel_err     = sel_err;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for vend_ctrl
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n;
  vend_ctrl_if #(.CW(6)) vif ();
  vend_ctrl #(.TO_CYC(10)) dut (.clk(clk), .rst(rst), .v(vif));
  always #5 clk = ~clk;
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clr();
    vif.coin5 = 0; vif.coin10 = 0; vif.sel_valid = 0; vif.sel = 0;
    vif.cancel = 0; vif.disp_ack = 0; vif.chg_ack = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic coins10(input int k);
    repeat (k) begin
      vif.coin10 = 1; tick(); vif.coin10 = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    clr();
    tick(2);
    rst = 0;
    chk("rst_credit", vif.credit, 0);
    chk("rst_disp_req", vif.disp_req, 0);
    chk("rst_chg_req", vif.chg_req, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_reject", vif.coin_reject, 0);
    chk("rst_sel_err", vif.sel_err, 0);
    chk("rst_item", vif.disp_item, 0);
    // exact pay
    coins10(1);
    vif.coin5 = 1; tick(); clr();
    chk("pay_credit3", vif.credit, 3);
    vif.sel_valid = 1; vif.sel = 0; tick(); clr();
    chk("pay_disp_req", vif.disp_req, 1);
    chk("pay_item", vif.disp_item, 0);
    chk("pay_busy", vif.busy, 1);
    tick();
    chk("pay_hold", vif.disp_req, 1);
    vif.disp_ack = 1; tick(); clr();
    chk("pay_credit0", vif.credit, 0);
    chk("pay_disp_drop", vif.disp_req, 0);
    chk("pay_no_chg", vif.chg_req, 0);
    chk("pay_idle", vif.busy, 0);
    // change
    coins10(4);
    chk("chg_credit8", vif.credit, 8);
    vif.sel_valid = 1; vif.sel = 2; tick(); clr();
    chk("chg_item", vif.disp_item, 2);
    vif.disp_ack = 1; tick(); clr();
    chk("chg_rem", vif.credit, 3);
    chk("chg_req", vif.chg_req, 1);
    chk("chg_disp_drop", vif.disp_req, 0);
    vif.chg_ack = 1;
    tick(); chk("chg_c2", vif.credit, 2);
    tick(); chk("chg_c1", vif.credit, 1);
    chk("chg_req_mid", vif.chg_req, 1);
    tick(); clr();
    chk("chg_c0", vif.credit, 0);
    chk("chg_req_end", vif.chg_req, 0);
    chk("chg_busy_end", vif.busy, 0);
    // insufficient credit
    coins10(1);
    vif.sel_valid = 1; vif.sel = 3; tick(); clr();
    chk("ins_sel_err", vif.sel_err, 1);
    chk("ins_credit", vif.credit, 2);
    chk("ins_no_disp", vif.disp_req, 0);
    tick();
    chk("ins_pulse", vif.sel_err, 0);
    // overflow
    coins10(8);
    vif.coin5 = 1; tick(); clr();
    chk("ovf_credit19", vif.credit, 19);
    vif.coin5 = 1; vif.coin10 = 1; tick(); clr();
    chk("ovf_reject", vif.coin_reject, 1);
    chk("ovf_credit", vif.credit, 19);
    vif.coin5 = 1; tick(); clr();
    chk("ovf_credit20", vif.credit, 20);
    chk("ovf_accept", vif.coin_reject, 0);
    vif.coin5 = 1; tick(); clr();
    chk("ovf_full_reject", vif.coin_reject, 1);
    chk("ovf_full_credit", vif.credit, 20);
    vif.cancel = 1; tick(); clr();
    chk("ovf_cancel_chg", vif.chg_req, 1);
    vif.chg_ack = 1; tick(20);
    chk("ovf_drain", vif.credit, 0);
    chk("ovf_drain_req", vif.chg_req, 0);
    tick();
    chk("ack_ignored_idle", vif.credit, 0);
    clr();
    // priority: cancel beats selection beats coin
    coins10(3);
    vif.cancel = 1; vif.sel_valid = 1; vif.sel = 0; vif.coin5 = 1; tick(); clr();
    chk("pri_reject", vif.coin_reject, 1);
    chk("pri_chg_req", vif.chg_req, 1);
    chk("pri_no_disp", vif.disp_req, 0);
    chk("pri_credit", vif.credit, 6);
    chk("pri_busy", vif.busy, 1);
    vif.chg_ack = 1; tick(6); clr();
    chk("pri_drain", vif.credit, 0);
    chk("pri_chg_end", vif.chg_req, 0);
    // coins and cancel during DISPENSE
    coins10(2);
    vif.sel_valid = 1; vif.sel = 1; tick(); clr();
    vif.coin5 = 1; tick(); clr();
    chk("dsp_reject", vif.coin_reject, 1);
    chk("dsp_credit", vif.credit, 4);
    vif.cancel = 1; tick(); clr();
    chk("dsp_cancel_ign", vif.disp_req, 1);
    chk("dsp_no_chg", vif.chg_req, 0);
    vif.disp_ack = 1; tick(); clr();
    chk("dsp_done", vif.credit, 0);
    chk("dsp_idle", vif.busy, 0);
    // reset mid-CHANGE
    coins10(2);
    vif.cancel = 1; tick(); clr();
    chk("rc_chg_req", vif.chg_req, 1);
    rst = 1; tick();
    chk("rc_chg_drop", vif.chg_req, 0);
    tick(); rst = 0;
    chk("rc_credit", vif.credit, 0);
    chk("rc_busy", vif.busy, 0);
    chk("rc_disp", vif.disp_req, 0);
    // timeout
    vif.coin5 = 1; tick(); clr();
    chk("to_credit1", vif.credit, 1);
`ifdef VEND_TIMEOUT_EN
    n = 0;
    while (vif.chg_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 11);
    chk("to_chg_req", vif.chg_req, 1);
    chk("to_credit", vif.credit, 1);
    vif.chg_ack = 1; tick(); clr();
`else
    n = 0;
    tick(300);
    chk("to_hold_credit", vif.credit, 1);
    chk("to_hold_chg", vif.chg_req, 0);
    vif.cancel = 1; tick(); clr();
    vif.chg_ack = 1; tick(); clr();
`endif
    chk("to_final", vif.credit, 0);
    chk("to_final_req", vif.chg_req, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
